// File: rtl/act_bus_arb.sv
// act_bus_arb: round-robin arbiter that shares one upstream activation beat
// stream among N_SBLK sblk_ctrl requesters. Each grant forwards exactly that
// requester's burst length of beats, registered, and then re-arbitrates.
module act_bus_arb #(
  parameter int unsigned N_SBLK     = 4,
  parameter int unsigned WID_N_SBLK = $clog2(N_SBLK),
  parameter int unsigned WID_ACT    = 16,
  parameter int unsigned WID_BURST  = 8
) (
  input  logic                        clk_l,
  input  logic                        rst,
  input  logic [N_SBLK-1:0]           req,
  input  logic [N_SBLK*WID_BURST-1:0] burst_len,
  input  logic                        src_vld,
  input  logic [2*WID_ACT-1:0]        src_data,
  output logic                        src_rdy,
  output logic [N_SBLK-1:0]           gnt,
  output logic [WID_N_SBLK-1:0]       gnt_idx,
  output logic [N_SBLK-1:0]           out_vld,
  output logic [2*WID_ACT-1:0]        out_data,
  output logic                        busy
);

  localparam int unsigned WID_BEAT = 2 * WID_ACT;

  typedef enum logic {
    IDLE = 1'b0,
    XFER = 1'b1
  } state_t;

  // Registered state and outputs
  state_t                 state_q,    state_d;
  logic [N_SBLK-1:0]      gnt_q,      gnt_d;
  logic [WID_N_SBLK-1:0]  gnt_idx_q,  gnt_idx_d;
  logic [N_SBLK-1:0]      out_vld_q,  out_vld_d;
  logic [WID_BEAT-1:0]    out_data_q, out_data_d;
  logic                   busy_q,     busy_d;
  logic [WID_BURST-1:0]   cnt_q,      cnt_d;
  logic [WID_N_SBLK-1:0]  rr_ptr_q,   rr_ptr_d;

  // Arbitration results
  logic                   win_found;
  logic [WID_N_SBLK-1:0]  win_idx;
  logic [WID_N_SBLK-1:0]  cand;
  logic [WID_BURST-1:0]   win_len;
  logic                   beat_acc;

  // The upstream port is open exactly while a burst is being transferred
  assign src_rdy  = (state_q == XFER);
  assign beat_acc = src_vld && src_rdy;

  // Round-robin search: first requester after rr_ptr, wrapping around
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int unsigned i = 1; i <= N_SBLK; i++) begin
      cand = WID_N_SBLK'((32'(rr_ptr_q) + i) % N_SBLK);
      if (!win_found && req[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  // Burst length of the current winner, selected from the packed field
  always_comb begin
    win_len = '0;
    for (int unsigned i = 0; i < N_SBLK; i++) begin
      if (win_idx == WID_N_SBLK'(i)) begin
        win_len = burst_len[i*WID_BURST +: WID_BURST];
      end
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    gnt_idx_d  = gnt_idx_q;
    out_vld_d  = '0;
    out_data_d = out_data_q;
    busy_d     = busy_q;
    cnt_d      = cnt_q;
    rr_ptr_d   = rr_ptr_q;

    case (state_q)
      IDLE: begin
        if (win_found) begin
          // A zero-length winner still advances the pointer so the next
          // requester gets its turn on the following cycle.
          rr_ptr_d = win_idx;
          if (win_len != '0) begin
            gnt_d     = N_SBLK'(1) << win_idx;
            gnt_idx_d = win_idx;
            cnt_d     = win_len;
            busy_d    = 1'b1;
            state_d   = XFER;
          end
        end
      end

      XFER: begin
        if (beat_acc) begin
          out_data_d = src_data;
          out_vld_d  = gnt_q;
          cnt_d      = cnt_q - WID_BURST'(1);
          if (cnt_q == WID_BURST'(1)) begin
            gnt_d   = '0;
            busy_d  = 1'b0;
            state_d = IDLE;
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State register with synchronous reset; rr_ptr resets so sblk0 wins first
  always_ff @(posedge clk_l) begin
    if (rst) begin
      state_q    <= IDLE;
      gnt_q      <= '0;
      gnt_idx_q  <= '0;
      out_vld_q  <= '0;
      out_data_q <= '0;
      busy_q     <= 1'b0;
      cnt_q      <= '0;
      rr_ptr_q   <= WID_N_SBLK'(N_SBLK - 1);
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      gnt_idx_q  <= gnt_idx_d;
      out_vld_q  <= out_vld_d;
      out_data_q <= out_data_d;
      busy_q     <= busy_d;
      cnt_q      <= cnt_d;
      rr_ptr_q   <= rr_ptr_d;
    end
  end

  assign gnt      = gnt_q;
  assign gnt_idx  = gnt_idx_q;
  assign out_vld  = out_vld_q;
  assign out_data = out_data_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_act_bus_arb.sv
// tb_act_bus_arb: directed scenarios plus randomized traffic, checked every
// cycle against a transaction-level reference model of the arbiter.
module tb_act_bus_arb;

  localparam int N  = 4;
  localparam int WB = 8;
  localparam int WA = 16;

  logic              clk_l = 1'b0;
  logic              rst;
  logic [N-1:0]      req;
  logic [N*WB-1:0]   burst_len;
  logic              src_vld;
  logic [2*WA-1:0]   src_data;
  logic              src_rdy;
  logic [N-1:0]      gnt;
  logic [1:0]        gnt_idx;
  logic [N-1:0]      out_vld;
  logic [2*WA-1:0]   out_data;
  logic              busy;

  always #5 clk_l = ~clk_l;

  act_bus_arb #(.N_SBLK(N), .WID_N_SBLK(2), .WID_ACT(WA), .WID_BURST(WB)) dut (
    .clk_l(clk_l), .rst(rst), .req(req), .burst_len(burst_len),
    .src_vld(src_vld), .src_data(src_data), .src_rdy(src_rdy),
    .gnt(gnt), .gnt_idx(gnt_idx), .out_vld(out_vld), .out_data(out_data),
    .busy(busy)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: who owns the bus, how many beats remain, RR pointer
  bit          m_xfer;
  int          m_owner;
  int          m_left;
  int          m_rr;
  int          m_vld_owner;
  logic [31:0] m_data;

  // Observations of the DUT for scenario-level checks
  int          beats;
  int          glog[$];
  logic [31:0] dlog[$];
  logic [N-1:0] prev_gnt;
  int          seq;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_update();
    if (rst) begin
      m_xfer = 0; m_owner = 0; m_left = 0; m_rr = N - 1;
      m_vld_owner = -1; m_data = '0;
    end else begin
      m_vld_owner = -1;
      if (m_xfer) begin
        if (src_vld) begin
          m_data = src_data;
          m_vld_owner = m_owner;
          m_left = m_left - 1;
          if (m_left == 0) m_xfer = 0;
        end
      end else begin
        for (int k = 1; k <= N; k++) begin
          int c;
          c = (m_rr + k) % N;
          if (req[c]) begin
            m_rr = c;
            if (int'(burst_len[c*WB +: WB]) > 0) begin
              m_xfer = 1; m_owner = c; m_left = int'(burst_len[c*WB +: WB]);
            end
            break;
          end
        end
      end
    end
  endtask

  task automatic compare_all();
    logic [N-1:0] e_gnt;
    logic [N-1:0] e_vld;
    e_gnt = m_xfer ? (N'(1) << m_owner) : '0;
    e_vld = (m_vld_owner >= 0) ? (N'(1) << m_vld_owner) : '0;
    check_eq("gnt", 64'(gnt), 64'(e_gnt));
    check_eq("gnt_idx", 64'(gnt_idx), 64'(m_owner));
    check_eq("busy", 64'(busy), 64'(m_xfer));
    check_eq("src_rdy", 64'(src_rdy), 64'(m_xfer));
    check_eq("out_vld", 64'(out_vld), 64'(e_vld));
    check_eq("out_data", 64'(out_data), 64'(m_data));
    if (out_vld != '0) begin
      beats++;
      dlog.push_back(out_data);
    end
    if (gnt != '0 && prev_gnt == '0) glog.push_back(int'(gnt_idx));
    prev_gnt = gnt;
  endtask

  // One clock: model follows the edge, DUT sampled on the falling edge
  task automatic step();
    @(posedge clk_l);
    model_update();
    if (m_vld_owner >= 0) seq++;
    @(negedge clk_l);
    compare_all();
    src_data = 32'(seq);
  endtask

  task automatic clear_logs();
    beats = 0;
    glog.delete();
    dlog.delete();
  endtask

  task automatic do_reset();
    rst = 1'b1; req = '0; src_vld = 1'b0;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic set_len(input int idx, input int len);
    burst_len[idx*WB +: WB] = WB'(len);
  endtask

  initial begin
    rst = 1'b1; req = '0; burst_len = '0; src_vld = 1'b0; src_data = '0;
    seq = 0; prev_gnt = '0;
    clear_logs();

    // Reset values
    do_reset();
    check_eq("rst_gnt", 64'(gnt), 64'(0));
    check_eq("rst_busy", 64'(busy), 64'(0));
    check_eq("rst_src_rdy", 64'(src_rdy), 64'(0));
    check_eq("rst_out_vld", 64'(out_vld), 64'(0));
    check_eq("rst_out_data", 64'(out_data), 64'(0));

    // Single requester, 8 beats carrying 0..7
    clear_logs();
    seq = 0; src_data = 32'(0);
    set_len(0, 8); req = 4'b0001; src_vld = 1'b1;
    step();
    check_eq("single_gnt", 64'(gnt), 64'(4'b0001));
    req = '0;
    for (int i = 0; i < 12; i++) step();
    check_eq("single_beats", 64'(beats), 64'(8));
    for (int i = 0; i < 8; i++) begin
      if (i < dlog.size()) check_eq("single_data", 64'(dlog[i]), 64'(i));
    end
    check_eq("single_busy_end", 64'(busy), 64'(0));
    check_eq("single_rdy_end", 64'(src_rdy), 64'(0));

    // Round robin with all requesting, 2 beats each
    do_reset();
    clear_logs();
    for (int i = 0; i < N; i++) set_len(i, 2);
    req = 4'b1111; src_vld = 1'b1;
    for (int i = 0; i < 16; i++) step();
    req = '0;
    for (int i = 0; i < 4; i++) step();
    check_eq("rr_count", 64'(glog.size()), 64'(6));
    for (int i = 0; i < 5; i++) begin
      if (i < glog.size()) check_eq("rr_order", 64'(glog[i]), 64'(i % N));
    end

    // Bubbles on src_vld
    do_reset();
    clear_logs();
    set_len(2, 4); req = 4'b0100; src_vld = 1'b0;
    step();
    req = '0;
    begin
      bit pat[7] = '{1, 0, 0, 1, 1, 0, 1};
      foreach (pat[i]) begin
        src_vld = pat[i];
        step();
      end
    end
    src_vld = 1'b0;
    for (int i = 0; i < 3; i++) step();
    check_eq("bubble_beats", 64'(beats), 64'(4));
    check_eq("bubble_busy", 64'(busy), 64'(0));

    // Zero-length requester is skipped, sblk0 granted again
    do_reset();
    clear_logs();
    set_len(0, 2); set_len(1, 0); req = 4'b0011; src_vld = 1'b1;
    for (int i = 0; i < 7; i++) step();
    req = '0;
    for (int i = 0; i < 4; i++) step();
    check_eq("zero_count", 64'(glog.size()), 64'(2));
    for (int i = 0; i < 2; i++) begin
      if (i < glog.size()) check_eq("zero_order", 64'(glog[i]), 64'(0));
    end

    // Request dropped mid-burst still completes
    clear_logs();
    set_len(1, 3); req = 4'b0010; src_vld = 1'b1;
    step();
    step();
    req = '0;
    for (int i = 0; i < 6; i++) step();
    check_eq("drop_beats", 64'(beats), 64'(3));

    // Reset mid-burst aborts, then sblk3 wins from the reset pointer
    do_reset();
    clear_logs();
    set_len(0, 6); req = 4'b0001; src_vld = 1'b1;
    step();
    req = '0;
    for (int i = 0; i < 3; i++) step();
    rst = 1'b1;
    step();
    check_eq("abort_gnt", 64'(gnt), 64'(0));
    check_eq("abort_vld", 64'(out_vld), 64'(0));
    check_eq("abort_rdy", 64'(src_rdy), 64'(0));
    check_eq("abort_busy", 64'(busy), 64'(0));
    rst = 1'b0; req = 4'b1000; set_len(3, 1);
    step();
    check_eq("abort_regnt", 64'(gnt), 64'(4'b1000));
    req = '0;
    for (int i = 0; i < 3; i++) step();

    // Maximum burst length completes without wrap
    do_reset();
    clear_logs();
    set_len(0, 255); req = 4'b0001; src_vld = 1'b1;
    step();
    req = '0;
    for (int i = 0; i < 262; i++) step();
    check_eq("max_beats", 64'(beats), 64'(255));
    check_eq("max_busy", 64'(busy), 64'(0));

    // Randomized traffic with occasional resets
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      rst = ($urandom_range(0, 299) == 0);
      req = N'($urandom_range(0, 3) == 0 ? 0 : $urandom);
      for (int j = 0; j < N; j++)
        set_len(j, ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 6)));
      src_vld = ($urandom_range(0, 3) != 0);
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/act_bus_arb.md
Name: act_bus_arb

Overview:
- Round-robin arbiter that shares one upstream activation stream (2 activations per beat) between N_SBLK sblk_ctrl instances.
- Each sblk_ctrl raises its act-in request level. The arbiter grants one requester at a time and forwards exactly that requester's burst length of beats to it, registered.
- The arbiter then re-arbitrates. It sits between the activation buffer/DMA read port and the sblk_ctrl act_in/act_in_vld/act_in_req ports.

Parameters:
- N_SBLK, 4, number of sblk_ctrl requesters.
- WID_N_SBLK, $clog2(N_SBLK), grant index width.
- WID_ACT, 16, single activation width; beat width is 2*WID_ACT.
- WID_BURST, 8, burst length field width in beats.

Ports:
- clk_l  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous reset, active-high.
- req  in  N_SBLK  level request per sblk (its act_in_req).
- burst_len  in  N_SBLK*WID_BURST  beats wanted per grant; slice i at [i*WID_BURST+:WID_BURST].
- src_vld  in  1  upstream beat valid.
- src_data  in  2*WID_ACT  upstream beat: low half = act k, high half = act k+1.
- src_rdy  out  1  arbiter accepts a beat this cycle.
- gnt  out  N_SBLK  one-hot current grant; held for the whole burst.
- gnt_idx  out  WID_N_SBLK  binary index of the current grant.
- out_vld  out  N_SBLK  per-sblk beat valid (drives act_in_vld).
- out_data  out  2*WID_ACT  beat data broadcast to all sblks.
- busy  out  1  burst in progress.

Behaviour:
- States: IDLE, XFER.
- Reset (rst=1 at a clk_l edge):
  - state=IDLE.
  - gnt=0, gnt_idx=0, out_vld=0, out_data=0, src_rdy=0, busy=0.
  - Beat counter=0.
  - rr_ptr=N_SBLK-1, so sblk0 wins first.
  - Reset mid-burst aborts immediately; the remaining beats are not delivered and no partial state survives.
- Arbitration, IDLE with |req:
  - Winner is the first i with req[i]=1, searching from (rr_ptr+1) mod N_SBLK upward with wrap.
  - Same edge: rr_ptr<=winner, gnt[winner]<=1, gnt_idx<=winner, cnt<=burst_len[winner], busy<=1, state<=XFER.
  - If burst_len[winner]==0: no grant is issued, gnt stays 0, rr_ptr<=winner, state stays IDLE, so the next requester can win next cycle.
- XFER:
  - src_rdy=1 combinationally from state==XFER.
  - A beat is accepted when src_vld && src_rdy.
  - On an accepted beat: out_data<=src_data, out_vld<=gnt (one-hot), cnt<=cnt-1. One-cycle latency from acceptance to out_vld.
  - With no beat accepted, out_vld<=0. Bubbles on src_vld are allowed and stall the counter.
  - On the accepted beat with cnt==1: state<=IDLE, gnt<=0, busy<=0. src_rdy is 0 from the next cycle.
  - The final out_vld pulse appears in the first IDLE cycle.
- Re-arbitration: at least one IDLE cycle between bursts, so a grant can never change while an out_vld from the previous burst is pending.
- Request semantics:
  - req is sampled only in IDLE.
  - Deassertion during XFER is ignored; the burst always completes.
  - burst_len is sampled only at grant; later changes affect the next grant only.
- out_data holds its last value when out_vld=0.
- out_vld is at most one-hot and is never set outside the granted index.
- Exactly burst_len beats are delivered per grant, with no duplicates and no drops.
- Simultaneous requests are served strictly in round-robin order. A requester that stays asserted waits at most N_SBLK-1 bursts.
- All N_SBLK requesting every cycle: grants go 0,1,2,3,0,...
- Counter width is WID_BURST. burst_len max (2^WID_BURST-1) must complete without wrap.

Test Plan:
- Single requester: req=4'b0001, burst_len[0]=8, src_vld=1 constant, data 0..7 → gnt=0001 one cycle after req; out_vld[0] high 8 consecutive cycles carrying 0..7; busy drops; src_rdy low after 8th beat.
- Round robin: req=4'b1111 held, all burst_len=2 → grant order 0,1,2,3,0; one IDLE cycle between each burst; out_vld only ever on granted bit.
- Bubbles: burst_len[2]=4, src_vld pattern 1,0,0,1,1,0,1 → exactly 4 beats out on out_vld[2], each one cycle after acceptance; the counter is unchanged during bubbles.
- Zero length / req drop: burst_len[1]=0 with req=4'b0011 after a grant to sblk0 → sblk1 is skipped without a grant and sblk0 is granted again. A separate grant with req dropped mid-burst still delivers the full burst.
- Reset mid-burst: rst=1 after beat 3 of 6 → next cycle gnt=0, out_vld=0, src_rdy=0, busy=0. After release with req=4'b1000, sblk3 is granted (rr_ptr reset to 3, search starts at 0, finds 3).
- Max length: burst_len[0]=255 → exactly 255 beats, then IDLE; no counter wrap.
